// File: rtl/time_counter.sv
// Time-of-day keeper for the alarm clock: HH:MM held as four BCD digits, 24h.
// Loads a new time from the keypad path. An out-of-range load is rejected.
// Advances one minute per one_minute pulse.
module time_counter #(
  parameter int MAX_HOUR   = 23,
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_time_ms_hr,
  input  logic [3:0] new_time_ls_hr,
  input  logic [3:0] new_time_ms_min,
  input  logic [3:0] new_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       load_error,
  output logic       day_wrap
);

  localparam logic [3:0] RST_MS_HR  = 4'(RESET_HOUR / 10);
  localparam logic [3:0] RST_LS_HR  = 4'(RESET_HOUR % 10);
  localparam logic [3:0] RST_MS_MIN = 4'(RESET_MIN / 10);
  localparam logic [3:0] RST_LS_MIN = 4'(RESET_MIN % 10);
  localparam logic [4:0] MAX_H5     = 5'(MAX_HOUR);
  localparam logic [7:0] MAX_H8     = 8'(MAX_HOUR);

  logic [3:0] ms_hr_q, ms_hr_d;
  logic [3:0] ls_hr_q, ls_hr_d;
  logic [3:0] ms_min_q, ms_min_d;
  logic [3:0] ls_min_q, ls_min_d;
  logic       load_error_q, load_error_d;
  logic       day_wrap_q, day_wrap_d;

  // Decoded hour of the held time. Stored digits are always in range, so 5 bits suffice.
  logic [4:0] cur_hour;
  // Requested hour. It is 8 bits wide so that illegal digit pairs cannot alias into range.
  logic [7:0] new_hour;
  logic       load_ok;

  assign cur_hour = 5'(ms_hr_q) * 5'd10 + 5'(ls_hr_q);
  assign new_hour = 8'(new_time_ms_hr) * 8'd10 + 8'(new_time_ls_hr);
  assign load_ok  = (new_time_ms_hr  <= 4'd9) && (new_time_ls_hr  <= 4'd9) &&
                    (new_time_ms_min <= 4'd5) && (new_time_ls_min <= 4'd9) &&
                    (new_hour <= MAX_H8);

  // Next state: a load takes priority; an increment that coincides with a load is dropped.
  always_comb begin
    ms_hr_d      = ms_hr_q;
    ls_hr_d      = ls_hr_q;
    ms_min_d     = ms_min_q;
    ls_min_d     = ls_min_q;
    load_error_d = 1'b0;
    day_wrap_d   = 1'b0;
    if (load_new_c) begin
      if (load_ok) begin
        ms_hr_d  = new_time_ms_hr;
        ls_hr_d  = new_time_ls_hr;
        ms_min_d = new_time_ms_min;
        ls_min_d = new_time_ls_min;
      end else begin
        load_error_d = 1'b1;
      end
    end else if (one_minute) begin
      if (ls_min_q == 4'd9) begin
        ls_min_d = 4'd0;
        if (ms_min_q == 4'd5) begin
          ms_min_d = 4'd0;
          if (cur_hour == MAX_H5) begin
            // End of day: the hour digits restart at 00.
            ms_hr_d    = 4'd0;
            ls_hr_d    = 4'd0;
            day_wrap_d = 1'b1;
          end else if (ls_hr_q == 4'd9) begin
            ls_hr_d = 4'd0;
            ms_hr_d = ms_hr_q + 4'd1;
          end else begin
            ls_hr_d = ls_hr_q + 4'd1;
          end
        end else begin
          ms_min_d = ms_min_q + 4'd1;
        end
      end else begin
        ls_min_d = ls_min_q + 4'd1;
      end
    end
  end

  // Digit and pulse registers. Reset is asynchronous and wins over everything else.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ms_hr_q      <= RST_MS_HR;
      ls_hr_q      <= RST_LS_HR;
      ms_min_q     <= RST_MS_MIN;
      ls_min_q     <= RST_LS_MIN;
      load_error_q <= 1'b0;
      day_wrap_q   <= 1'b0;
    end else begin
      ms_hr_q      <= ms_hr_d;
      ls_hr_q      <= ls_hr_d;
      ms_min_q     <= ms_min_d;
      ls_min_q     <= ls_min_d;
      load_error_q <= load_error_d;
      day_wrap_q   <= day_wrap_d;
    end
  end

  assign current_time_ms_hr  = ms_hr_q;
  assign current_time_ls_hr  = ls_hr_q;
  assign current_time_ms_min = ms_min_q;
  assign current_time_ls_min = ls_min_q;
  assign load_error          = load_error_q;
  assign day_wrap            = day_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed and random bench for time_counter.
// The reference model holds the time as minutes-of-day and converts to digits only at the comparison.
module tb_time_counter;
  localparam int MAX_HOUR   = 23;
  localparam int RESET_HOUR = 0;
  localparam int RESET_MIN  = 0;
  localparam int DAY        = (MAX_HOUR + 1) * 60;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_minute = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] n_mh = '0, n_lh = '0, n_mm = '0, n_lm = '0;
  logic [3:0] c_mh, c_lh, c_mm, c_lm;
  logic       load_error, day_wrap;

  int n_assert = 0;
  int n_fail   = 0;
  int model_min;
  bit exp_err, exp_wrap;

  time_counter #(.MAX_HOUR(MAX_HOUR), .RESET_HOUR(RESET_HOUR), .RESET_MIN(RESET_MIN)) dut (
    .clock(clock), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
    .new_time_ms_hr(n_mh), .new_time_ls_hr(n_lh),
    .new_time_ms_min(n_mm), .new_time_ls_min(n_lm),
    .current_time_ms_hr(c_mh), .current_time_ls_hr(c_lh),
    .current_time_ms_min(c_mm), .current_time_ls_min(c_lm),
    .load_error(load_error), .day_wrap(day_wrap)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_digits();
    int h, m;
    h = model_min / 60;
    m = model_min % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_time"}, {c_mh, c_lh, c_mm, c_lm}, model_digits());
    check({tag, "_err"},  16'(load_error), 16'(exp_err));
    check({tag, "_wrap"}, 16'(day_wrap),   16'(exp_wrap));
  endtask

  task automatic model_reset();
    model_min = RESET_HOUR * 60 + RESET_MIN;
    exp_err   = 1'b0;
    exp_wrap  = 1'b0;
  endtask

  // One clock cycle with the given request. The outputs are checked 1 time unit after the edge.
  task automatic step(input string tag, input bit ld, input bit om,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    int h;
    load_new_c = ld; one_minute = om;
    n_mh = a; n_lh = b; n_mm = c; n_lm = d;
    @(posedge clock); #1;
    exp_err = 1'b0; exp_wrap = 1'b0;
    h = int'(a) * 10 + int'(b);
    if (ld) begin
      if (a <= 9 && b <= 9 && c <= 5 && d <= 9 && h <= MAX_HOUR)
        model_min = h * 60 + int'(c) * 10 + int'(d);
      else
        exp_err = 1'b1;
    end else if (om) begin
      model_min = model_min + 1;
      if (model_min == DAY) begin
        model_min = 0;
        exp_wrap  = 1'b1;
      end
    end
    load_new_c = 1'b0; one_minute = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] a, b, c, d;
    int r;
    model_reset();
    #3 check_all("reset");
    #9 reset = 1'b0;

    // Idle after reset: nothing moves
    step("idle0", 0, 0, 0, 0, 0, 0);
    step("idle1", 0, 0, 0, 0, 0, 0);
    check("idle_const", {c_mh, c_lh, c_mm, c_lm}, 16'h0000);

    // Load 12:34, count one minute to 12:35, then 25 more minutes to 13:00
    step("ld1234", 1, 0, 1, 2, 3, 4);
    step("inc1235", 0, 1, 0, 0, 0, 0);
    check("c1235", {c_mh, c_lh, c_mm, c_lm}, 16'h1235);
    for (int i = 0; i < 25; i++) step("inc", 0, 1, 0, 0, 0, 0);
    check("c1300", {c_mh, c_lh, c_mm, c_lm}, 16'h1300);

    // Midnight wrap with a single-cycle day_wrap pulse
    step("ld2359", 1, 0, 2, 3, 5, 9);
    step("wrap", 0, 1, 0, 0, 0, 0);
    check("wrap_pulse", 16'(day_wrap), 16'h0001);
    step("wrap_after", 0, 0, 0, 0, 0, 0);

    // Rejected loads: the time holds and load_error pulses for one cycle
    step("ld0510", 1, 0, 0, 5, 1, 0);
    step("bad2400", 1, 0, 2, 4, 0, 0);
    step("bad0160", 1, 0, 0, 1, 6, 0);
    step("bad0A00", 1, 0, 0, 4'hA, 0, 0);
    check("bad_hold", {c_mh, c_lh, c_mm, c_lm}, 16'h0510);
    step("bad_after", 0, 0, 0, 0, 0, 0);

    // A load and a pulse in the same cycle: the load wins and the pulse is dropped
    step("ld_vs_inc", 1, 1, 0, 7, 1, 5);
    check("c0715", {c_mh, c_lh, c_mm, c_lm}, 16'h0715);

    // Count every cycle from 09:58, then apply reset asynchronously in mid-cycle
    step("ld0958", 1, 0, 0, 9, 5, 8);
    for (int i = 0; i < 3; i++) step("run", 0, 1, 0, 0, 0, 0);
    check("c1001", {c_mh, c_lh, c_mm, c_lm}, 16'h1001);
    one_minute = 1'b1;
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b0; one_minute = 1'b0;
    step("post_rst0", 0, 1, 0, 0, 0, 0);
    step("post_rst1", 0, 1, 0, 0, 0, 0);
    check("c0002", {c_mh, c_lh, c_mm, c_lm}, 16'h0002);

    // Random mix of loads, which may be legal or illegal, and minute pulses
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 3) begin
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
        step("rnd_ld", 1, $urandom_range(0, 1) == 1, a, b, c, d);
      end else if (r < 6) begin
        a = 4'($urandom_range(0, 2));
        b = (a == 2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 9));
        c = 4'($urandom_range(4, 5)); d = 4'($urandom_range(5, 9));
        step("rnd_ldv", 1, 0, a, b, c, d);
      end else begin
        step("rnd_inc", 0, r < 17, 0, 0, 0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
